// File: rtl/prom_arb_pkg.sv
// Shared definitions for the PROM arbiter and the 512x8 PROM part model.
package prom_arb_pkg;

  localparam int PROM_ADDR_W = 9;
  localparam int PROM_DATA_W = 8;
  localparam int WAIT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

endpackage

// File: rtl/prom_arbiter_rr_arb2.sv
// Two-input round-robin grant; a tie goes to the requester not granted last.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  output logic       o_valid,
  output logic       o_gnt_idx
);

  logic r_last_grant;

  always_comb begin
    o_valid   = |i_req;
    o_gnt_idx = (i_req == 2'b11) ? ~r_last_grant : i_req[1];
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (i_upd) begin
      r_last_grant <= o_gnt_idx;
    end
  end

endmodule

// File: rtl/prom_arbiter.sv
// Shares one asynchronous PROM between two requesters: grant, hold CE_N low
// for WAIT_CYCLES clocks, capture the byte, then pulse the granted ack.
//
// state     | meaning
// ST_IDLE   | PROM disabled, arbitrating pending requests
// ST_ACCESS | PROM enabled with latched address, counting down access time
// ST_ACK    | byte captured in rdata, granted ack high for this cycle
module prom_arbiter
  import prom_arb_pkg::*;
#(
  parameter int ADDR_W      = PROM_ADDR_W,
  parameter int DATA_W      = PROM_DATA_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] prom_a,
  output logic              prom_ce_n,
  input  logic [DATA_W-1:0] prom_d
);

  localparam logic [WAIT_W-1:0] CNT_LOAD = WAIT_W'(WAIT_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WAIT_W-1:0]   r_cnt;
  logic                r_gnt;
  logic [ADDR_W-1:0]   r_prom_a;
  logic                r_ce_n;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_req_vld;
  logic                w_gnt_idx;
  logic                w_grant;
  logic                w_cnt_done;

  assign w_grant    = (r_state == ST_IDLE) && w_req_vld;
  assign w_cnt_done = (r_cnt == '0);

  rr_arb2 u_rr (
    .clk       (clk),
    .reset     (reset),
    .i_req     ({req1, req0}),
    .i_upd     (w_grant),
    .o_valid   (w_req_vld),
    .o_gnt_idx (w_gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_req_vld) w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (w_cnt_done) w_state_nxt = ST_ACK;
      ST_ACK:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // prom_d is only looked at on the ACCESS->ACK edge; it may float otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_gnt    <= 1'b0;
      r_prom_a <= '0;
      r_ce_n   <= 1'b1;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_gnt    <= w_gnt_idx;
            r_prom_a <= w_gnt_idx ? addr1 : addr0;
            r_ce_n   <= 1'b0;
            r_cnt    <= CNT_LOAD;
          end
        end
        ST_ACCESS: begin
          if (w_cnt_done) begin
            r_rdata <= prom_d;
            r_ce_n  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ack0      = (r_state == ST_ACK) && !r_gnt;
  assign ack1      = (r_state == ST_ACK) &&  r_gnt;
  assign busy      = (r_state == ST_ACCESS) || (r_state == ST_ACK);
  assign prom_a    = r_prom_a;
  assign prom_ce_n = r_ce_n;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_prom_arbiter.sv
// Scoreboard bench for prom_arbiter: three instances at WAIT_CYCLES 1, 3 and 4,
// each driven in turn, sharing one expected-ack queue and one monitor.
module tb_prom_arbiter;

  typedef struct {
    int         inst;
    logic       who;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst    [3];
  logic       req0   [3];
  logic       req1   [3];
  logic [8:0] addr0  [3];
  logic [8:0] addr1  [3];
  logic       ack0   [3];
  logic       ack1   [3];
  logic [7:0] rdata  [3];
  logic       busy   [3];
  logic [8:0] prom_a [3];
  logic       ce_n   [3];
  logic [7:0] prom_d [3];
  logic       force_x[3];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_acks   = 0;

  function automatic logic [7:0] rom(input logic [8:0] a);
    case (a)
      9'h005:  return 8'hA5;
      9'h010:  return 8'h11;
      9'h1FF:  return 8'h22;
      9'h100:  return 8'h5A;
      default: return a[7:0] ^ 8'h3C;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    prom_arbiter #(.WAIT_CYCLES(W)) u_dut (
      .clk(clk), .reset(rst[g]),
      .req0(req0[g]), .addr0(addr0[g]), .ack0(ack0[g]),
      .req1(req1[g]), .addr1(addr1[g]), .ack1(ack1[g]),
      .rdata(rdata[g]), .busy(busy[g]),
      .prom_a(prom_a[g]), .prom_ce_n(ce_n[g]), .prom_d(prom_d[g])
    );
    assign prom_d[g] = (ce_n[g] || force_x[g]) ? 8'hxx : rom(prom_a[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int inst, input logic who, input logic [7:0] data);
    exp_t e;
    e.inst = inst; e.who = who; e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every ack pops one expected transaction.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ack0[i] && ack1[i]) check("ack_exclusive", 16'h3, 16'h1);
      if (ack0[i] || ack1[i]) begin
        n_acks++;
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 16'(i), 16'hFFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ack_inst", 16'(i), 16'(e.inst));
          check("ack_who", {15'd0, ack1[i]}, {15'd0, e.who});
          check("ack_rdata", {8'd0, rdata[i]}, {8'd0, e.data});
        end
      end
    end
  end

  initial begin
    int ack_t[$];
    int idle_cnt;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req0[i] = 1'b0; req1[i] = 1'b0;
      addr0[i] = '0; addr1[i] = '0; force_x[i] = 1'b0;
    end
    repeat (2) tick();
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    check("rst_ce_n", {15'd0, ce_n[0]}, 16'h1);
    check("rst_prom_a", {7'd0, prom_a[0]}, 16'h0);
    check("rst_rdata", {8'd0, rdata[0]}, 16'h0);
    check("rst_acks", {14'd0, ack0[0], ack1[0]}, 16'h0);
    check("rst_busy", {15'd0, busy[0]}, 16'h0);

    // Single read, WAIT_CYCLES=1
    req0[0] = 1'b1; addr0[0] = 9'h005; push(0, 1'b0, 8'hA5);
    tick();
    req0[0] = 1'b0;
    check("single_ce_low", {15'd0, ce_n[0]}, 16'h0);
    check("single_prom_a", {7'd0, prom_a[0]}, 16'h005);
    check("single_ack_early", {15'd0, ack0[0]}, 16'h0);
    tick();
    check("single_ack0", {15'd0, ack0[0]}, 16'h1);
    check("single_ack1", {15'd0, ack1[0]}, 16'h0);
    check("single_ce_high", {15'd0, ce_n[0]}, 16'h1);
    check("single_rdata", {8'd0, rdata[0]}, 16'h00A5);
    tick();
    check("single_ack_pulse", {15'd0, ack0[0]}, 16'h0);
    check("single_busy", {15'd0, busy[0]}, 16'h0);

    // Tie and fairness from a fresh last_grant
    rst[0] = 1'b1; tick(); rst[0] = 1'b0;
    req0[0] = 1'b1; addr0[0] = 9'h010;
    req1[0] = 1'b1; addr1[0] = 9'h1FF;
    push(0, 1'b0, 8'h11); push(0, 1'b1, 8'h22);
    push(0, 1'b0, 8'h11); push(0, 1'b1, 8'h22);
    tick();
    check("tie_g0_addr", {7'd0, prom_a[0]}, 16'h010);
    repeat (3) tick();
    check("tie_g1_addr", {7'd0, prom_a[0]}, 16'h1FF);
    repeat (3) tick();
    check("tie_g2_addr", {7'd0, prom_a[0]}, 16'h010);
    repeat (4) tick();
    check("tie_last_ack1", {15'd0, ack1[0]}, 16'h1);
    req0[0] = 1'b0; req1[0] = 1'b0;
    repeat (4) tick();
    check("tie_ack_count", 16'(n_acks), 16'd5);

    // Wait states, WAIT_CYCLES=3, data floats until the last access cycle
    req1[1] = 1'b1; addr1[1] = 9'h100; force_x[1] = 1'b1; push(1, 1'b1, 8'h5A);
    tick();
    req1[1] = 1'b0;
    check("ws_ce_c1", {15'd0, ce_n[1]}, 16'h0);
    check("ws_prom_a", {7'd0, prom_a[1]}, 16'h100);
    tick();
    check("ws_ce_c2", {15'd0, ce_n[1]}, 16'h0);
    force_x[1] = 1'b0;
    tick();
    check("ws_ce_c3", {15'd0, ce_n[1]}, 16'h0);
    check("ws_no_ack_yet", {15'd0, ack1[1]}, 16'h0);
    tick();
    check("ws_ack1", {15'd0, ack1[1]}, 16'h1);
    check("ws_ack0", {15'd0, ack0[1]}, 16'h0);
    check("ws_ce_high", {15'd0, ce_n[1]}, 16'h1);
    check("ws_rdata", {8'd0, rdata[1]}, 16'h005A);
    tick();

    // Address and req churn after grant
    req0[0] = 1'b1; addr0[0] = 9'h020; push(0, 1'b0, 8'h1C);
    tick();
    addr0[0] = 9'h0AA; req0[0] = 1'b0;
    check("churn_prom_a", {7'd0, prom_a[0]}, 16'h020);
    tick();
    check("churn_ack0", {15'd0, ack0[0]}, 16'h1);
    check("churn_prom_a_hold", {7'd0, prom_a[0]}, 16'h020);
    repeat (3) tick();
    check("churn_no_regrant", {15'd0, ce_n[0]}, 16'h1);

    // Reset mid-access, WAIT_CYCLES=4
    req0[2] = 1'b1; addr0[2] = 9'h005;
    tick();
    req0[2] = 1'b0;
    tick();
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    check("mrst_ce_n", {15'd0, ce_n[2]}, 16'h1);
    check("mrst_busy", {15'd0, busy[2]}, 16'h0);
    check("mrst_rdata", {8'd0, rdata[2]}, 16'h0);
    req0[2] = 1'b1; addr0[2] = 9'h010;
    req1[2] = 1'b1; addr1[2] = 9'h1FF;
    push(2, 1'b0, 8'h11);
    tick();
    req0[2] = 1'b0; req1[2] = 1'b0;
    check("mrst_tie_addr", {7'd0, prom_a[2]}, 16'h010);
    repeat (7) tick();

    // Back-to-back single requester, WAIT_CYCLES=1
    req0[0] = 1'b1; addr0[0] = 9'h005;
    push(0, 1'b0, 8'hA5); push(0, 1'b0, 8'hA5); push(0, 1'b0, 8'hA5);
    idle_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (ack0[0]) begin
        ack_t.push_back(c);
        if (ack_t.size() == 3) req0[0] = 1'b0;
      end
      if (!busy[0] && ack_t.size() > 0 && ack_t.size() < 3) idle_cnt++;
    end
    check("b2b_ack_count", 16'(ack_t.size()), 16'd3);
    if (ack_t.size() == 3) begin
      check("b2b_gap1", 16'(ack_t[1] - ack_t[0]), 16'd3);
      check("b2b_gap2", 16'(ack_t[2] - ack_t[1]), 16'd3);
    end
    check("b2b_idle_cycles", 16'(idle_cnt), 16'd2);

    repeat (2) tick();
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    check("total_acks", 16'(n_acks), 16'd11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prom_arbiter.md
# prom_arbiter

Sequences and shares one 512x8 bipolar boot/mapping PROM (CE_N-gated, tri-state outputs, asynchronous access) between two synchronous requesters. Each requester presents an address with a level request; the arbiter grants round-robin, drives the PROM address and chip enable, and waits a fixed number of clocks for access time. It then captures the byte and returns it with a one-cycle acknowledge. It sits between the PROM part model and its consumers, for example a boot microcode loader and a debug/console read port.

## Interface
- ADDR_W, 9, PROM address width
- DATA_W, 8, PROM data width
- WAIT_CYCLES, 1, clocks the PROM is enabled before data is sampled; legal range 1..15

- clk  in  1  sole clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0  in  1  requester 0 read request, level
- addr0  in  ADDR_W  requester 0 address, sampled at grant
- ack0  out  1  one-cycle pulse: rdata valid for requester 0
- req1  in  1  requester 1 read request, level
- addr1  in  ADDR_W  requester 1 address, sampled at grant
- ack1  out  1  one-cycle pulse: rdata valid for requester 1
- rdata  out  DATA_W  captured PROM byte; holds until next capture
- busy  out  1  high in ACCESS and ACK states
- prom_a  out  ADDR_W  PROM address, registered
- prom_ce_n  out  1  PROM chip enable, active low, registered
- prom_d  in  DATA_W  PROM data; may be Z/X while prom_ce_n=1

## Operation
- States: IDLE, ACCESS, ACK.
- IDLE: if no req, stay; prom_ce_n=1. If any req, grant per round-robin, latch the granted address into prom_a, set prom_ce_n=0, load wait counter with WAIT_CYCLES-1, go to ACCESS.
- Round-robin: register last_grant. Both requesting → grant the one != last_grant; single request → grant it. last_grant updates on every grant.
- ACCESS: counter decrements each cycle. At counter==0: rdata<=prom_d, prom_ce_n<=1, assert the granted ack, go to ACK.
- ACK: the granted ack is high for exactly this cycle; no grant is evaluated; next state IDLE.
- A requester holding req high through ack issues a new request, sampled in the following IDLE with its then-current address. To stop, it drops req no later than the cycle after ack.
- Dropping req during ACCESS does not abort; the transaction completes and ack still pulses.
- Address changes after grant are ignored; prom_a holds until the next grant.
- prom_d is sampled only at the ACCESS→ACK edge; its value at any other time is don't-care.
- ack0 and ack1 are never high together.

## Timing
- Reset values: state=IDLE, prom_ce_n=1, prom_a=0, rdata=0, ack0=ack1=0, busy=0, counter=0, last_grant=1 (req0 wins first tie).
- Reset mid-transaction: abort immediately on the reset edge; no ack; prom_ce_n=1 the next cycle.
- Edge E0: req seen in IDLE. prom_ce_n low and prom_a valid from E0 for WAIT_CYCLES cycles. Data is captured at edge E0+WAIT_CYCLES. ack is high in the cycle following that edge.
- Request-to-ack latency is WAIT_CYCLES+1 cycles after the sampling edge.
- Back-to-back throughput is one read per WAIT_CYCLES+2 cycles.
- Counter width is 4 bits. WAIT_CYCLES=1 loads 0, so ACCESS lasts exactly one cycle.

## Structure
- Shared package prom_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_ACK=2'd2
  - counter width WAIT_W=4
  - default ADDR_W/DATA_W shared with the PROM part model
- One natural sub-module is rr_arb2: a two-input round-robin grant with last_grant register and an update strobe. It is reusable for other shared parts.
- Everything else lives in prom_arbiter as one FSM plus datapath registers.

## Test plan
- Single read: WAIT_CYCLES=1, PROM[0x005]=0xA5, req0 with addr0=0x005 → prom_ce_n low exactly one cycle with prom_a=0x005; ack0 is one pulse two cycles after the sampling edge; rdata=0xA5; ack1 stays 0.
- Tie and fairness: req0 and req1 both held high, addr0=0x010 (0x11), addr1=0x1FF (0x22) → grants alternate 0,1,0,1; first ack is ack0; rdata alternates 0x11/0x22; never both acks.
- Wait states: WAIT_CYCLES=3, req1 with addr1=0x100 (0x5A) → prom_ce_n low 3 cycles; ack1 four cycles after the sampling edge; rdata=0x5A; prom_d driven X before the last ACCESS cycle does not corrupt rdata.
- Address and req churn: change addr0 and drop req0 one cycle after grant → prom_a unchanged, transaction completes, ack0 still pulses, no further grant.
- Reset mid-access: WAIT_CYCLES=4, assert reset during ACCESS cycle 2 → next cycle prom_ce_n=1, state IDLE, no ack, rdata=0; a following req1 tie with req0 grants req0 first.
- Back-to-back single requester: req0 high for 3 transactions at WAIT_CYCLES=1 → acks spaced exactly 3 cycles apart; busy low exactly one cycle between transactions.
